cellram_ctrl: RTL

// Initiator for the 8M x16 CellularRAM synchronous burst interface. Takes config, read-burst and

---
 rtl/cellram_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cellram_ctrl.sv
`timescale 1ns/1ps
// cellram_ctrl: synchronous burst initiator for an 8M x16 CellularRAM.
// Host commands (read burst, write burst, config-register write) are turned
// into ce/we/oe/adv/cre/lb/ub/addr/data pin activity. Write data is staged in
// an internal FIFO so a burst never stalls once started; read words stream
// out on rd_data/rd_valid with no backpressure.
module cellram_ctrl #(
  parameter int FIFO_AW = 8,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [22:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_oe,
  output logic        mem_adv,
  output logic        mem_lb,
  output logic        mem_ub,
  output logic        mem_cre,
  output logic [22:0] mem_addr,
  inout  wire  [15:0] mem_data,
  input  logic        mem_wait
);

  localparam int CW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FILL,
    S_ADDR,
    S_LAT,
    S_XFER,
    S_CFG,
    S_CFG_WAIT,
    S_END,
    S_ERR
  } state_t;

  state_t state;
  state_t next;

  // latched command
  logic [1:0]  cur_op;
  logic [7:0]  cur_len;
  logic [22:0] addr_q;

  // shared phase counter: latency/timeout count, then transfer beat count
  logic [15:0] cnt;
  logic        wait_pol;

  // write FIFO
  logic [15:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      pop_n;
  logic               push;

  logic        accept;
  logic        is_wr;
  logic [8:0]  burst_words;
  logic        wait_off;
  logic        burst_ready;
  logic        xfer_last;
  logic        lat_expired;
  logic        rd_capture;
  logic        drive_data;

  // Wait is deasserted when the pin differs from the configured polarity.
  function automatic logic wait_inactive(input logic w, input logic pol);
    return w != pol;
  endfunction

  assign accept      = cmd_valid && (state == S_IDLE);
  assign is_wr       = (cur_op == 2'd1);
  assign burst_words = {1'b0, cur_len} + 9'd1;
  // the first latency cycle is ignored: the memory has not yet driven wait
  assign wait_off    = wait_inactive(mem_wait, wait_pol) && (cnt != 16'd0);
  assign burst_ready = (fifo_count >= CW'(burst_words));
  assign xfer_last   = is_wr ? (cnt == 16'(cur_len))
                             : (cnt == 16'(cur_len) + 16'(RD_LAT));
  assign lat_expired = (cnt == 16'(TIMEOUT - 1));
  assign rd_capture  = (state == S_XFER) && !is_wr && (cnt >= 16'(RD_LAT));
  assign drive_data  = (state == S_XFER) && is_wr;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign wr_ready  = (fifo_count != CW'(DEPTH));
  assign push      = wr_valid && wr_ready;
  assign mem_addr  = addr_q;
  assign mem_data  = drive_data ? fifo_mem[rd_ptr] : 16'bz;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  // Next-state logic.
  always_comb begin
    next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'd1:    next = S_FILL;
            2'd2:    next = S_CFG;
            default: next = S_ADDR;
          endcase
        end
      end
      S_FILL:     if (burst_ready) next = S_ADDR;
      S_ADDR:     next = S_LAT;
      S_LAT: begin
        if (wait_off)         next = S_XFER;
        else if (lat_expired) next = S_ERR;
      end
      S_XFER:     if (xfer_last) next = S_END;
      S_CFG:      next = S_CFG_WAIT;
      S_CFG_WAIT: begin
        if (wait_off)         next = S_END;
        else if (lat_expired) next = S_ERR;
      end
      S_END:      next = S_IDLE;
      S_ERR:      next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  // Memory pin controls decoded from the current state.
  always_comb begin
    mem_ce  = 1'b1;
    mem_we  = 1'b1;
    mem_oe  = 1'b1;
    mem_adv = 1'b1;
    mem_lb  = 1'b1;
    mem_ub  = 1'b1;
    mem_cre = 1'b0;
    case (state)
      S_ADDR: begin
        mem_ce  = 1'b0;
        mem_adv = 1'b0;
        mem_we  = !is_wr;
        mem_lb  = 1'b0;
        mem_ub  = 1'b0;
      end
      S_LAT: begin
        mem_ce = 1'b0;
        mem_we = !is_wr;
        mem_lb = 1'b0;
        mem_ub = 1'b0;
      end
      S_XFER: begin
        mem_ce = 1'b0;
        mem_we = !is_wr;
        mem_oe = is_wr;
        mem_lb = 1'b0;
        mem_ub = 1'b0;
      end
      S_CFG: begin
        mem_ce  = 1'b0;
        mem_cre = 1'b1;
        mem_adv = 1'b0;
        mem_we  = 1'b0;
      end
      S_CFG_WAIT: begin
        mem_ce = 1'b0;
      end
      default: ;
    endcase
  end

  // Phase counter restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (next != state)  cnt <= '0;
    else                     cnt <= cnt + 16'd1;
  end

  // Command latch and debug address that tracks the memory's own increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_op  <= 2'd0;
      cur_len <= 8'd0;
      addr_q  <= '0;
    end else if (accept) begin
      cur_op  <= cmd_op;
      cur_len <= cmd_len;
      addr_q  <= cmd_addr;
    end else if (state == S_XFER) begin
      addr_q  <= addr_q + 23'd1;
    end
  end

  // Wait polarity follows BCR bit 10 after a successful config write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wait_pol <= 1'b1;
    else if ((state == S_CFG_WAIT) && wait_off)
      wait_pol <= addr_q[10];
  end

  // Sticky error flag, cleared by the next accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                err <= 1'b0;
    else if (accept)           err <= 1'b0;
    else if (state == S_ERR)   err <= 1'b1;
  end

  // Read strobe; reset clears it immediately so no partial word escapes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= rd_capture;
  end

  // Read word capture from the memory bus.
  always_ff @(posedge clk) begin
    if (rd_capture) rd_data <= mem_data;
  end

  // FIFO pop amount: one word per write beat, or the whole aborted burst.
  always_comb begin
    pop_n = '0;
    if (is_wr) begin
      if (state == S_XFER)     pop_n = CW'(1);
      else if (state == S_ERR) pop_n = CW'(burst_words);
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop both take effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      rd_ptr     <= rd_ptr + pop_n[FIFO_AW-1:0];
      fifo_count <= fifo_count + CW'(push) - pop_n;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

endmodule
